// File: rtl/ahb_uart_loader.sv
// ahb_uart_loader: packs a UART byte stream into 32-bit words and writes them
// to incrementing addresses as single NONSEQ AHB-Lite word writes.
module ahb_uart_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          IMAGE_WORDS = 1024
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVERRUN,
  output logic        ERROR
);
  typedef enum logic [1:0] {IDLE, WAIT_WORD, ADDR, DATA} state_t;
  state_t      state_q, state_d;
  logic [31:0] haddr_q, hwdata_q, buf_q;
  logic [23:0] asm_q;
  logic [15:0] wcnt_q;
  logic [1:0]  bcnt_q;
  logic        full_q, done_q, ovr_q, err_q;
  logic        take, wdone, rel, fail, last, go;
  assign take  = BYTE_VALID && state_q != IDLE;
  assign wdone = take && bcnt_q == 2'd3;
  assign rel   = state_q == DATA && HREADY && !HRESP;
  assign fail  = state_q == DATA && HREADY && HRESP;
  assign last  = {1'b0, wcnt_q} + 17'd1 == 17'(IMAGE_WORDS);
  assign go    = state_q == IDLE && START;
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (START) state_d = WAIT_WORD;
      WAIT_WORD: if (full_q) state_d = ADDR;
      ADDR:      if (HREADY) state_d = DATA;
      DATA:      if (fail) state_d = IDLE;
                 else if (rel) state_d = last ? IDLE : wdone ? ADDR : WAIT_WORD;
    endcase
  end
  always_comb begin
    HTRANS  = state_q == ADDR ? 2'b10 : 2'b00;
    HWRITE  = state_q == ADDR;
    HSIZE   = 3'b010;
    HADDR   = haddr_q;
    HWDATA  = hwdata_q;
    BUSY    = state_q != IDLE;
    DONE    = done_q;
    OVERRUN = ovr_q;
    ERROR   = err_q;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      haddr_q  <= BASE_ADDR;
      hwdata_q <= '0;
      buf_q    <= '0;
      asm_q    <= '0;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= rel && last;
      if (take) bcnt_q <= bcnt_q + 2'd1;
      if (take && !wdone) asm_q[{bcnt_q, 3'b000} +: 8] <= BYTE_IN;
      // a word completing on the release cycle reuses the buffer being freed
      if (wdone) begin
        if (full_q && !rel) ovr_q <= 1'b1;
        else begin
          buf_q  <= {BYTE_IN, asm_q};
          full_q <= 1'b1;
        end
      end else if (rel) full_q <= 1'b0;
      if (state_q == ADDR && HREADY) hwdata_q <= buf_q;
      if (rel) begin
        wcnt_q  <= wcnt_q + 16'd1;
        haddr_q <= haddr_q + 32'd4;
      end
      if (fail) begin
        err_q  <= 1'b1;
        full_q <= 1'b0;
        bcnt_q <= '0;
      end
      if (go) begin
        haddr_q <= BASE_ADDR;
        wcnt_q  <= '0;
        bcnt_q  <= '0;
        full_q  <= 1'b0;
        ovr_q   <= 1'b0;
        err_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ahb_uart_loader.sv
// tb_ahb_uart_loader: directed scenario tests for ahb_uart_loader with a bus
// monitor that logs every completed write.
module tb_ahb_uart_loader;
  localparam logic [31:0] BASE = 32'h2000_0000;
  logic        HCLK = 0, HRESET = 1, START = 0, BYTE_VALID = 0, HREADY = 1, HRESP = 0;
  logic [7:0]  BYTE_IN = 0;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, BUSY, DONE, OVERRUN, ERROR;
  logic [2:0]  HSIZE;
  int vec = 0, miss = 0;
  int wr_n = 0, done_n = 0;
  logic [31:0] wr_addr [0:31];
  logic [31:0] wr_data [0:31];
  logic        pend = 0;
  logic [31:0] paddr = 0;
  ahb_uart_loader #(.BASE_ADDR(BASE), .IMAGE_WORDS(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .START(START), .BYTE_IN(BYTE_IN),
    .BYTE_VALID(BYTE_VALID), .HREADY(HREADY), .HRESP(HRESP), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN), .ERROR(ERROR));
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) begin
    if (HRESET) pend <= 0;
    else begin
      if (DONE) done_n <= done_n + 1;
      if (pend && HREADY) begin
        pend <= 0;
        if (!HRESP) begin
          wr_addr[wr_n[4:0]] <= paddr;
          wr_data[wr_n[4:0]] <= HWDATA;
          wr_n <= wr_n + 1;
        end
      end
      if (HTRANS == 2'b10 && HREADY) begin
        pend  <= 1;
        paddr <= HADDR;
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask
  task automatic send(input logic [7:0] b);
    BYTE_VALID = 1; BYTE_IN = b; tick(); BYTE_VALID = 0;
  endtask
  task automatic start();
    START = 1; tick(); START = 0;
  endtask
  task automatic test_reset();
    HRESET = 1; tick(2); HRESET = 0;
    vec++; if (HTRANS !== 2'b00) begin miss++; $display("FAIL rst_htrans got %h want 0", HTRANS); end
    vec++; if (HADDR !== BASE) begin miss++; $display("FAIL rst_haddr got %h want %h", HADDR, BASE); end
    vec++; if (HWDATA !== 32'h0) begin miss++; $display("FAIL rst_hwdata got %h want 0", HWDATA); end
    vec++; if ({HWRITE, BUSY, DONE, OVERRUN, ERROR} !== 5'b0) begin miss++; $display("FAIL rst_flags got %b want 00000", {HWRITE, BUSY, DONE, OVERRUN, ERROR}); end
    vec++; if (HSIZE !== 3'b010) begin miss++; $display("FAIL rst_hsize got %b want 010", HSIZE); end
  endtask
  task automatic test_basic();
    int w0, d0;
    logic [7:0] b [0:7];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    w0 = wr_n; d0 = done_n; HREADY = 1;
    start();
    vec++; if (BUSY !== 1'b1) begin miss++; $display("FAIL basic_busy got %b want 1", BUSY); end
    for (int i = 0; i < 8; i++) begin send(b[i]); tick(2); end
    tick(4);
    vec++; if (wr_n - w0 !== 2) begin miss++; $display("FAIL basic_count got %0d want 2", wr_n - w0); end
    vec++; if (wr_addr[w0] !== 32'h2000_0000 || wr_data[w0] !== 32'h4433_2211) begin miss++; $display("FAIL basic_w0 got %h/%h want 20000000/44332211", wr_addr[w0], wr_data[w0]); end
    vec++; if (wr_addr[w0+1] !== 32'h2000_0004 || wr_data[w0+1] !== 32'h8877_6655) begin miss++; $display("FAIL basic_w1 got %h/%h want 20000004/88776655", wr_addr[w0+1], wr_data[w0+1]); end
    vec++; if (done_n - d0 !== 1) begin miss++; $display("FAIL basic_done got %0d want 1", done_n - d0); end
    vec++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin miss++; $display("FAIL basic_idle got busy %b done %b want 0 0", BUSY, DONE); end
  endtask
  task automatic test_wait_states();
    int w0, d0;
    w0 = wr_n; d0 = done_n; HREADY = 0;
    start();
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    tick();
    for (int i = 0; i < 3; i++) begin
      vec++; if (HTRANS !== 2'b10 || HADDR !== BASE || HWRITE !== 1'b1) begin miss++; $display("FAIL wait_addr%0d got %h/%h/%b want 2/%h/1", i, HTRANS, HADDR, HWRITE, BASE); end
      tick();
    end
    HREADY = 1; tick(); HREADY = 0;
    for (int i = 0; i < 2; i++) begin
      vec++; if (HTRANS !== 2'b00 || HWDATA !== 32'hD4C3_B2A1) begin miss++; $display("FAIL wait_data%0d got %h/%h want 0/d4c3b2a1", i, HTRANS, HWDATA); end
      tick();
    end
    HREADY = 1; tick();
    vec++; if (wr_n - w0 !== 1 || wr_data[w0] !== 32'hD4C3_B2A1) begin miss++; $display("FAIL wait_one got %0d writes data %h want 1 d4c3b2a1", wr_n - w0, wr_data[w0]); end
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick(5);
    vec++; if (wr_n - w0 !== 2 || wr_addr[w0+1] !== 32'h2000_0004 || wr_data[w0+1] !== 32'h0403_0201) begin miss++; $display("FAIL wait_w1 got %0d %h/%h want 2 20000004/04030201", wr_n - w0, wr_addr[w0+1], wr_data[w0+1]); end
    vec++; if (done_n - d0 !== 1) begin miss++; $display("FAIL wait_done got %0d want 1", done_n - d0); end
  endtask
  task automatic test_simultaneous();
    int w0;
    w0 = wr_n;
    start();
    for (int i = 0; i < 8; i++) begin
      BYTE_VALID = 1; BYTE_IN = 8'(8'h10 + i); HREADY = (i != 6); tick();
    end
    BYTE_VALID = 0; HREADY = 1;
    vec++; if (OVERRUN !== 1'b0) begin miss++; $display("FAIL sim_ovr got %b want 0", OVERRUN); end
    vec++; if (HTRANS !== 2'b10 || HADDR !== 32'h2000_0004) begin miss++; $display("FAIL sim_addr got %h/%h want 2/20000004", HTRANS, HADDR); end
    tick(4);
    vec++; if (wr_n - w0 !== 2 || wr_data[w0] !== 32'h1312_1110 || wr_data[w0+1] !== 32'h1716_1514) begin miss++; $display("FAIL sim_data got %0d %h %h want 2 13121110 17161514", wr_n - w0, wr_data[w0], wr_data[w0+1]); end
  endtask
  task automatic test_overrun();
    int w0, d0;
    w0 = wr_n; d0 = done_n; HREADY = 0;
    start();
    for (int i = 0; i < 8; i++) send(8'(8'hA1 + i));
    vec++; if (OVERRUN !== 1'b1 || wr_n != w0) begin miss++; $display("FAIL ovr_flag got %b writes %0d want 1 0", OVERRUN, wr_n - w0); end
    HREADY = 1; tick(4);
    vec++; if (wr_n - w0 !== 1 || wr_data[w0] !== 32'hA4A3_A2A1) begin miss++; $display("FAIL ovr_w0 got %0d %h want 1 a4a3a2a1", wr_n - w0, wr_data[w0]); end
    vec++; if (HTRANS !== 2'b00 || BUSY !== 1'b1 || HADDR !== 32'h2000_0004) begin miss++; $display("FAIL ovr_wait got %h/%b/%h want 0/1/20000004", HTRANS, BUSY, HADDR); end
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    tick(5);
    vec++; if (wr_n - w0 !== 2 || wr_data[w0+1] !== 32'hC4C3_C2C1 || done_n - d0 !== 1) begin miss++; $display("FAIL ovr_w1 got %0d %h done %0d want 2 c4c3c2c1 1", wr_n - w0, wr_data[w0+1], done_n - d0); end
    vec++; if (OVERRUN !== 1'b1) begin miss++; $display("FAIL ovr_sticky got %b want 1", OVERRUN); end
  endtask
  task automatic test_error();
    int w0, d0;
    w0 = wr_n; HREADY = 1;
    start();
    for (int i = 0; i < 4; i++) send(8'(8'hE0 + i));
    tick(2);
    HRESP = 1; HREADY = 0; tick();
    vec++; if (HTRANS !== 2'b00 || ERROR !== 1'b0 || BUSY !== 1'b1) begin miss++; $display("FAIL err_first got %h/%b/%b want 0/0/1", HTRANS, ERROR, BUSY); end
    HREADY = 1; tick(); HRESP = 0;
    vec++; if (ERROR !== 1'b1 || BUSY !== 1'b0 || HTRANS !== 2'b00) begin miss++; $display("FAIL err_flag got %b/%b/%h want 1/0/0", ERROR, BUSY, HTRANS); end
    vec++; if (wr_n != w0) begin miss++; $display("FAIL err_nowrite got %0d want 0", wr_n - w0); end
    d0 = done_n;
    start();
    vec++; if (ERROR !== 1'b0 || BUSY !== 1'b1 || HADDR !== BASE) begin miss++; $display("FAIL err_restart got %b/%b/%h want 0/1/%h", ERROR, BUSY, HADDR, BASE); end
    for (int i = 0; i < 8; i++) send(8'(8'h50 + i));
    tick(6);
    vec++; if (wr_n - w0 !== 2 || wr_addr[w0] !== BASE || wr_data[w0] !== 32'h5352_5150 || wr_addr[w0+1] !== 32'h2000_0004 || done_n - d0 !== 1) begin miss++; $display("FAIL err_reload got %0d %h/%h %h done %0d", wr_n - w0, wr_addr[w0], wr_data[w0], wr_addr[w0+1], done_n - d0); end
  endtask
  task automatic test_reset_midload();
    int w0;
    w0 = wr_n; HREADY = 0;
    start();
    for (int i = 0; i < 4; i++) send(8'(8'h90 + i));
    tick();
    vec++; if (HTRANS !== 2'b10) begin miss++; $display("FAIL rml_addr got %h want 2", HTRANS); end
    HRESET = 1; tick(); HRESET = 0; HREADY = 1;
    vec++; if (HTRANS !== 2'b00 || BUSY !== 1'b0 || HADDR !== BASE) begin miss++; $display("FAIL rml_abort got %h/%b/%h want 0/0/%h", HTRANS, BUSY, HADDR, BASE); end
    for (int i = 0; i < 8; i++) send(8'(8'h70 + i));
    tick(4);
    vec++; if (wr_n != w0 || BUSY !== 1'b0 || HTRANS !== 2'b00) begin miss++; $display("FAIL rml_ignore got %0d writes busy %b htrans %h want 0 0 0", wr_n - w0, BUSY, HTRANS); end
  endtask
  initial begin
    fork
      begin
        test_reset();
        test_basic();
        test_wait_states();
        test_simultaneous();
        test_overrun();
        test_error();
        test_reset_midload();
      end
      begin
        #200000;
        miss++;
        $display("FAIL timeout got running want finished");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
